// File: rtl/mux_stream_n_if.sv
// Stream-out multiplexer bus: frame load handshake plus per-beat output handshake.
interface mux_stream_n_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [SEL_W:0]            count;
    logic                      load_valid;
    logic                      load_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    // Environment side: supplies frames and consumes beats.
    modport master (
        output in_bus, count, load_valid, out_ready,
        input  load_ready, out_data, out_sel, out_valid, out_last
    );

    // Block side: accepts frames and produces beats.
    modport slave (
        input  in_bus, count, load_valid, out_ready,
        output load_ready, out_data, out_sel, out_valid, out_last
    );
endinterface

// File: rtl/mux_stream_n.sv
// Captures a frame of CHANNELS words and streams the first N of them out one
// beat per accepted transfer, tagging each beat with its channel index.
module mux_stream_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_stream_n_if.slave bus
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Beat count used when the requested count is 0 or out of range.
    localparam logic [SEL_W:0] CNT_MAX = (SEL_W + 1)'(CHANNELS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] frame_q [CHANNELS];
    logic [WIDTH-1:0] frame_d [CHANNELS];
    logic [SEL_W:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             last_beat;

    // State register: frame store, effective count, beat index and FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the frame store is reset on purpose so an aborted frame leaves
            // no stale data visible on out_data.
            state_q <= IDLE;
            frame_q <= '{default: '0};
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the
            // values of the previous cycle, independent of statement order.
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic: load a frame in IDLE, advance the index on each accepted beat.
    always_comb begin
        // NOTE: hold-by-default assignments first, so no path leaves a signal
        // unassigned and no latch is inferred.
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        last_beat = ({1'b0, sel_q} == (cnt_q - 1'b1));

        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        frame_d[k] = bus.in_bus[k*WIDTH +: WIDTH];
                    end
                    if (bus.count == '0 || bus.count > CNT_MAX) begin
                        cnt_d = CNT_MAX;
                    end else begin
                        cnt_d = bus.count;
                    end
                    sel_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshakes follow the state, data comes from the frame store.
    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.out_valid  = (state_q == STREAM);
        bus.out_last   = (state_q == STREAM) && last_beat;
        bus.out_sel    = sel_q;
        bus.out_data   = frame_q[sel_q];
    end

endmodule

// File: tb/tb_mux_stream_n.sv
// Scoreboard bench for mux_stream_n: loads directed frames, queues the expected
// beats, and a negedge monitor compares every presented beat against the queue.
module tb_mux_stream_n;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 16;
    localparam int SEL_W    = $clog2(CHANNELS);

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    beat_t exp_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    mux_stream_n_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    mux_stream_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: while a beat is presented it must match the queue head; it is
    // retired only when out_ready accepts it, so stalls re-check the same beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(bus.out_sel), 64'hFFFF);
                end else begin
                    check("beat_sel",  64'(bus.out_sel),  64'(exp_q[0].sel));
                    check("beat_data", 64'(bus.out_data), 64'(exp_q[0].data));
                    check("beat_last", 64'(bus.out_last), 64'(exp_q[0].last));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("last_without_valid", 64'(bus.out_last), 64'd0);
            end
        end
    end

    // Present a frame with channel k = base + k, queue its expected beats, load it,
    // then scramble in_bus/count so later changes cannot leak into the frame.
    task automatic do_load(input int c, input logic [WIDTH-1:0] base);
        int eff;
        eff = (c == 0 || c > CHANNELS) ? CHANNELS : c;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.in_bus[k*WIDTH +: WIDTH] = base + WIDTH'(k);
        end
        bus.count      = (SEL_W + 1)'(c);
        bus.load_valid = 1'b1;
        check("load_ready_idle", 64'(bus.load_ready), 64'd1);
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back('{sel: SEL_W'(i), data: base + WIDTH'(i), last: (i == eff - 1)});
        end
        step();
        bus.load_valid = 1'b0;
        bus.in_bus     = {CHANNELS{16'hDEAD}};
        bus.count      = (SEL_W + 1)'(2);
        check("first_valid", 64'(bus.out_valid),  64'd1);
        check("first_sel",   64'(bus.out_sel),    64'd0);
        check("busy_ready",  64'(bus.load_ready), 64'd0);
    endtask

    // Drive out_ready from a repeating pattern until the queue drains, then
    // confirm the block is back in IDLE.
    task automatic wait_frame(input logic [7:0] pat, input int len);
        logic [7:0] p;
        p = pat;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            bus.out_ready = p[i % len];
            step();
        end
        check("frame_done",       64'(exp_q.size()),   64'd0);
        check("end_valid_low",    64'(bus.out_valid),  64'd0);
        check("end_load_ready",   64'(bus.load_ready), 64'd1);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_bus     = '0;
        bus.count      = '0;
        bus.load_valid = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) step();
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_last",   64'(bus.out_last),   64'd0);
        check("rst_out_sel",    64'(bus.out_sel),    64'd0);
        check("rst_out_data",   64'(bus.out_data),   64'd0);
        rst_n = 1'b1;
        step();
        check("rst_load_ready", 64'(bus.load_ready), 64'd1);

        // Full 16-channel frame, no back-pressure.
        do_load(16, 16'h1000);
        wait_frame(8'hFF, 1);

        // Three beats with stalls: ready sequence 1,0,0,1,1.
        do_load(3, 16'h2000);
        wait_frame(8'b0001_1001, 5);

        // Clamp: count 0 and count above CHANNELS both stream all channels.
        do_load(0, 16'h3000);
        wait_frame(8'hFF, 1);
        do_load(20, 16'h4000);
        wait_frame(8'b0000_0110, 3);

        // Single-beat frame is its own last beat.
        do_load(1, 16'h5000);
        check("single_last", 64'(bus.out_last), 64'd1);
        wait_frame(8'hFF, 1);
        step();
        check("single_idle", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a frame aborts it.
        do_load(16, 16'h6000);
        bus.out_ready = 1'b1;
        repeat (5) step();
        check("sel_before_rst", 64'(bus.out_sel), 64'd5);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_data",  64'(bus.out_data),  64'd0);
        check("abort_sel",   64'(bus.out_sel),   64'd0);
        rst_n = 1'b1;
        step();
        check("abort_load_ready", 64'(bus.load_ready), 64'd1);
        do_load(16, 16'h7000);
        wait_frame(8'hFF, 1);

        // Load attempts and in_bus churn during STREAM must be ignored.
        do_load(8, 16'h8000);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1'b1;
            bus.in_bus     = {CHANNELS{16'(i * 16'h1111)}};
            bus.count      = (SEL_W + 1)'(1);
            check("stream_ready_low", 64'(bus.load_ready), 64'd0);
            step();
        end
        bus.load_valid = 1'b0;
        wait_frame(8'b0000_0101, 3);
        repeat (3) step();
        check("no_extra_load", 64'(bus.out_valid), 64'd0);
        do_load(2, 16'h9000);
        wait_frame(8'hFF, 1);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
